hazard_ctrl: RTL and testbench

//  Parametrised pipeline hazard controller for the MIPS32 core. Combines load-use, multi-cycle
//  MDU, data-memory wait, control-transfer and exception hazards into per-stage stall and bubble

---
 rtl/hazard_ctrl.sv | 176 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard controller. Merges exception, data-memory wait, MDU,
//   load-use and control-transfer hazards into per-stage stall/flush vectors.
//   It also tracks the MDU countdown and a flush deferred behind a stall, and
//   keeps a saturating count of cycles in which the PC is held.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   RUN   | no MDU operation outstanding
//   MDU   | MDU countdown in progress (mdu_cnt cycles left, EX held)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active-low
//   load_use   ID operand depends on load currently in EX
//   mdu_start  MDU op issued in EX this cycle (pulse)
//   mem_req    MEM stage access valid
//   mem_ready  data memory completes access this cycle
//   ctrl_taken branch taken / jump resolved in ID
//   exc_valid  exception raised in MEM
//   cnt_clr    synchronous clear of stall_cnt
//   stall      stall[i]=1 holds register feeding stage i (stall[0] = PC hold)
//   flush      flush[i]=1 loads a bubble into register feeding stage i
//   mdu_busy   MDU countdown in progress
//   stall_cnt  saturating count of cycles with stall[0]=1

module hazard_ctrl #(
    parameter int NUM_STAGES = 5,
    parameter int ID_STAGE   = 1,
    parameter int EX_STAGE   = 2,
    parameter int MEM_STAGE  = 3,
    parameter int MDU_LAT    = 4,
    parameter int DELAY_SLOT = 1,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_use,
    input  logic                  mdu_start,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    input  logic                  ctrl_taken,
    input  logic                  exc_valid,
    input  logic                  cnt_clr,
    output logic [NUM_STAGES-1:0] stall,
    output logic [NUM_STAGES-1:0] flush,
    output logic                  mdu_busy,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam int MC_W = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;

    typedef enum logic {RUN, MDU} state_t;

    state_t          state, state_nx;
    logic [MC_W-1:0] mdu_cnt, mdu_cnt_nx;
    logic            flush_pend, flush_pend_nx;
    logic            run_en;

    logic gate;
    logic lu_e, ms_e, mreq_e, mrdy_e, ct_e, exc_e, clr_e;
    logic memw, mdu_stall, pend_set;
    int   stall_k, bubble_k;

    // Inputs are ignored while reset is held and until the first edge after
    // release, so nothing leaks out of the pipeline before it is running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) run_en <= 1'b0;
        else      run_en <= 1'b1;
    end

    assign gate   = rst & run_en;
    assign lu_e   = load_use   & gate;
    assign ms_e   = mdu_start  & gate;
    assign mreq_e = mem_req    & gate;
    assign mrdy_e = mem_ready  & gate;
    assign ct_e   = ctrl_taken & gate;
    assign exc_e  = exc_valid  & gate;
    assign clr_e  = cnt_clr    & gate;

    assign mdu_busy  = (state == MDU);
    assign memw      = mreq_e & ~mrdy_e;
    assign mdu_stall = mdu_busy | ms_e;

    always_comb begin
        stall    = '0;
        flush    = '0;
        stall_k  = -1;
        bubble_k = -1;
        pend_set = 1'b0;
        if (exc_e) begin
            for (int i = 0; i < NUM_STAGES; i++)
                flush[i] = (i >= ID_STAGE) && (i <= MEM_STAGE);
        end else begin
            if (memw) begin
                stall_k  = MEM_STAGE;
                bubble_k = MEM_STAGE + 1;
            end else if (mdu_stall) begin
                stall_k  = EX_STAGE;
                bubble_k = EX_STAGE + 1;
            end else if (lu_e) begin
                stall_k  = ID_STAGE;
                bubble_k = EX_STAGE;
            end
            // A bubble index past the last stage simply matches nothing.
            for (int i = 0; i < NUM_STAGES; i++) begin
                stall[i] = (i <= stall_k);
                flush[i] = (i == bubble_k);
            end
            if (stall_k < 0 && ct_e && DELAY_SLOT == 0)
                flush[ID_STAGE] = 1'b1;
            // Deferred flush lands on the first cycle ID is free to move;
            // a fresh ctrl_taken on that same cycle merges into it.
            if (flush_pend && !stall[ID_STAGE])
                flush[ID_STAGE] = 1'b1;
            pend_set = ct_e && (DELAY_SLOT == 0) && (memw || mdu_stall);
        end
    end

    always_comb begin
        state_nx      = state;
        mdu_cnt_nx    = mdu_cnt;
        flush_pend_nx = flush_pend;
        if (exc_e) begin
            state_nx      = RUN;
            mdu_cnt_nx    = '0;
            flush_pend_nx = 1'b0;
        end else begin
            if (pend_set)
                flush_pend_nx = 1'b1;
            else if (flush_pend && !stall[ID_STAGE])
                flush_pend_nx = 1'b0;
            case (state)
                RUN: begin
                    // Single-cycle MDU needs only the issue-cycle stall.
                    if (ms_e && MDU_LAT > 1) begin
                        state_nx   = MDU;
                        mdu_cnt_nx = MC_W'(MDU_LAT - 1);
                    end
                end
                MDU: begin
                    if (!memw) begin
                        if (mdu_cnt == MC_W'(1)) begin
                            state_nx   = RUN;
                            mdu_cnt_nx = '0;
                        end else begin
                            mdu_cnt_nx = mdu_cnt - MC_W'(1);
                        end
                    end
                end
                default: begin
                    state_nx   = RUN;
                    mdu_cnt_nx = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RUN;
            mdu_cnt    <= '0;
            flush_pend <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            state      <= state_nx;
            mdu_cnt    <= mdu_cnt_nx;
            flush_pend <= flush_pend_nx;
            if (clr_e)
                stall_cnt <= '0;
            else if (stall[0] && !(&stall_cnt))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int N  = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_use, mdu_start, mem_req, mem_ready;
    logic          ctrl_taken, exc_valid, cnt_clr;
    logic [N-1:0]  stall, flush;
    logic          mdu_busy;
    logic [CW-1:0] stall_cnt;

    hazard_ctrl #(
        .NUM_STAGES(N), .ID_STAGE(1), .EX_STAGE(2), .MEM_STAGE(3),
        .MDU_LAT(4), .DELAY_SLOT(0), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .load_use(load_use), .mdu_start(mdu_start),
        .mem_req(mem_req), .mem_ready(mem_ready), .ctrl_taken(ctrl_taken),
        .exc_valid(exc_valid), .cnt_clr(cnt_clr), .stall(stall),
        .flush(flush), .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic         lu, ms, mr, rdy, ct, exc, clr;
        logic [N-1:0] es, ef;
        logic         eb;
    } vec_t;

    typedef struct {
        string         name;
        logic [N-1:0]  s, f;
        logic          b;
        logic [CW-1:0] c;
    } exp_t;

    vec_t          tbl[$];
    exp_t          sbq[$];
    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] model_cnt = '0;

    task automatic add(input string n, input logic lu, ms, mr, rdy, ct, exc, clr,
                       input logic [N-1:0] es, ef, input logic eb);
        vec_t v;
        v.name = n; v.lu = lu; v.ms = ms; v.mr = mr; v.rdy = rdy;
        v.ct = ct; v.exc = exc; v.clr = clr; v.es = es; v.ef = ef; v.eb = eb;
        tbl.push_back(v);
    endtask

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endtask

    task automatic drive(input logic lu, ms, mr, rdy, ct, exc, clr);
        load_use = lu; mdu_start = ms; mem_req = mr; mem_ready = rdy;
        ctrl_taken = ct; exc_valid = exc; cnt_clr = clr;
    endtask

    // Drive one cycle, queue its expectation, compare before the next edge,
    // then advance the stall-counter model for that edge.
    task automatic apply(input vec_t v);
        exp_t e, g;
        @(negedge clk);
        drive(v.lu, v.ms, v.mr, v.rdy, v.ct, v.exc, v.clr);
        e.name = v.name; e.s = v.es; e.f = v.ef; e.b = v.eb; e.c = model_cnt;
        sbq.push_back(e);
        #3;
        g = sbq.pop_front();
        chk({g.name, ".stall"},     32'(stall),     32'(g.s));
        chk({g.name, ".flush"},     32'(flush),     32'(g.f));
        chk({g.name, ".mdu_busy"},  32'(mdu_busy),  32'(g.b));
        chk({g.name, ".stall_cnt"}, 32'(stall_cnt), 32'(g.c));
        if (v.clr)
            model_cnt = '0;
        else if (v.es[0] && model_cnt != '1)
            model_cnt = model_cnt + 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        //   name       lu ms mr rd ct ex cl  stall     flush     busy
        add("idle0",    0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0);
        add("lu",       1, 0, 0, 0, 0, 0, 0, 5'b00011, 5'b00100, 0);
        add("lu_after", 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0);
        add("mdu_s",    0, 1, 0, 0, 0, 0, 0, 5'b00111, 5'b01000, 0);
        add("mdu_b1",   0, 0, 0, 0, 0, 0, 0, 5'b00111, 5'b01000, 1);
        add("mdu_b2",   0, 0, 0, 0, 0, 0, 0, 5'b00111, 5'b01000, 1);
        add("mdu_b3",   0, 0, 0, 0, 0, 0, 0, 5'b00111, 5'b01000, 1);
        add("mdu_done", 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0);
        add("mw_s",     0, 1, 0, 0, 0, 0, 0, 5'b00111, 5'b01000, 0);
        add("mw_b1",    0, 0, 0, 0, 0, 0, 0, 5'b00111, 5'b01000, 1);
        add("mw_w1",    0, 0, 1, 0, 0, 0, 0, 5'b01111, 5'b10000, 1);
        add("mw_w2",    0, 0, 1, 0, 0, 0, 0, 5'b01111, 5'b10000, 1);
        add("mw_rdy",   0, 0, 1, 1, 0, 0, 0, 5'b00111, 5'b01000, 1);
        add("mw_b3",    0, 0, 0, 0, 0, 0, 0, 5'b00111, 5'b01000, 1);
        add("mw_done",  0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0);
        add("dfm_ct",   0, 0, 1, 0, 1, 0, 0, 5'b01111, 5'b10000, 0);
        add("dfm_rel",  0, 0, 1, 1, 0, 0, 0, 5'b00000, 5'b00010, 0);
        add("dfm_idle", 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0);
        add("dfd_ct",   0, 1, 0, 0, 1, 0, 0, 5'b00111, 5'b01000, 0);
        add("dfd_b1",   0, 0, 0, 0, 0, 0, 0, 5'b00111, 5'b01000, 1);
        add("dfd_b2",   0, 0, 0, 0, 0, 0, 0, 5'b00111, 5'b01000, 1);
        add("dfd_b3",   0, 0, 0, 0, 0, 0, 0, 5'b00111, 5'b01000, 1);
        add("dfd_merge",0, 0, 0, 0, 1, 0, 0, 5'b00000, 5'b00010, 0);
        add("dfd_idle", 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0);
        add("dfl_ct",   0, 0, 1, 0, 1, 0, 0, 5'b01111, 5'b10000, 0);
        add("dfl_lu",   1, 0, 0, 0, 0, 0, 0, 5'b00011, 5'b00100, 0);
        add("dfl_rel",  0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00010, 0);
        add("dfl_idle", 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0);
        add("ct",       0, 0, 0, 0, 1, 0, 0, 5'b00000, 5'b00010, 0);
        add("ex_s",     0, 1, 0, 0, 0, 0, 0, 5'b00111, 5'b01000, 0);
        add("ex_exc",   0, 0, 0, 0, 0, 1, 0, 5'b00000, 5'b01110, 1);
        add("ex_after", 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0);
        add("exm_ct",   0, 0, 1, 0, 1, 0, 0, 5'b01111, 5'b10000, 0);
        add("exm_exc",  0, 0, 1, 0, 0, 1, 0, 5'b00000, 5'b01110, 0);
        add("exm_idle", 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0);
        add("mem_ok",   0, 0, 1, 1, 0, 0, 0, 5'b00000, 5'b00000, 0);
        add("ml_s",     1, 1, 0, 0, 0, 0, 0, 5'b00111, 5'b01000, 0);
        add("ml_b1",    1, 0, 0, 0, 0, 0, 0, 5'b00111, 5'b01000, 1);
        add("ml_b2",    0, 0, 0, 0, 0, 0, 0, 5'b00111, 5'b01000, 1);
        add("ml_b3",    0, 0, 0, 0, 0, 0, 0, 5'b00111, 5'b01000, 1);
        add("ml_done",  0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0);
        add("clr_idle", 0, 0, 0, 0, 0, 0, 1, 5'b00000, 5'b00000, 0);
        add("clr_stall",1, 0, 0, 0, 0, 0, 1, 5'b00011, 5'b00100, 0);
        add("clr_chk",  0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0);

        rst = 1'b0;
        drive(1, 1, 1, 0, 1, 0, 0);
        #2;
        chk("rst_hold.stall", 32'(stall), 32'h0);
        chk("rst_hold.flush", 32'(flush), 32'h0);
        chk("rst_hold.cnt",   32'(stall_cnt), 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i]);

        // Reset mid-MDU with a deferred flush pending.
        v = tbl[18]; v.name = "rm_ct";  apply(v);
        v = tbl[19]; v.name = "rm_b1";  apply(v);
        @(negedge clk);
        drive(1, 0, 1, 0, 1, 0, 0);
        #2 rst = 1'b0;
        #1;
        chk("rm_rst.stall", 32'(stall),     32'h0);
        chk("rm_rst.flush", 32'(flush),     32'h0);
        chk("rm_rst.busy",  32'(mdu_busy),  32'h0);
        chk("rm_rst.cnt",   32'(stall_cnt), 32'h0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rm_rel.stall", 32'(stall), 32'h0);
        chk("rm_rel.flush", 32'(flush), 32'h0);
        model_cnt = '0;
        add("rm_idle1", 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0);
        add("rm_idle2", 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0);
        add("rm_lu",    1, 0, 0, 0, 0, 0, 0, 5'b00011, 5'b00100, 0);
        add("rm_cnt",   0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0);
        for (int i = tbl.size() - 4; i < tbl.size(); i++)
            apply(tbl[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
